// File: rtl/riscv_pipe_pkg.sv
// Purpose : shared control-word bit map, load-size encodings and MEM/WB FSM states.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: CTRL_* bit indices into the 8-bit control word, LS_* load-size codes,
//           wb_state_t enum used by mem_wb_stage.
package riscv_pipe_pkg;

   // Control word bit indices; bits [7:6] are reserved and ignored.
   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_BRANCH   = 2;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_MEMREAD  = 4;
   localparam int CTRL_LINK     = 5;

   // Load size encodings; 2'b11 is handled as a word.
   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   typedef enum logic {
      RUN       = 1'b0,
      LOAD_WAIT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Purpose : MEM -> WB handshake and register-file write bundle.
// Latency : n/a (wiring only).
// Backpressure: stall_req travels back towards MEM; everything else flows forward.
// Ports   : in_* / mem_rvalid driven by the MEM side (master), stall_req and
//           wb_* / retire / load_err / instret driven by the WB stage (slave).
interface mem_wb_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic [4:0]      in_reg_addr;
   logic [7:0]      in_control;
   logic [XLEN-1:0] in_regdata;
   logic [XLEN-1:0] in_memdata;
   logic [XLEN-1:0] in_pc;
   logic [1:0]      in_ls;
   logic            in_ls_unsigned;
   logic            mem_rvalid;
   logic            stall_req;
   logic            wb_we;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            retire;
   logic            load_err;
   logic [63:0]     instret;

   modport master (
      output in_valid, in_reg_addr, in_control, in_regdata, in_memdata,
             in_pc, in_ls, in_ls_unsigned, mem_rvalid,
      input  stall_req, wb_we, wb_addr, wb_data, retire, load_err, instret
   );

   modport slave (
      input  in_valid, in_reg_addr, in_control, in_regdata, in_memdata,
             in_pc, in_ls, in_ls_unsigned, mem_rvalid,
      output stall_req, wb_we, wb_addr, wb_data, retire, load_err, instret
   );
endinterface

// File: rtl/mem_wb_stage_load_extract.sv
// Purpose : pick byte/half/word out of the aligned memory word and extend it.
// Latency : combinational.
// Backpressure: none.
// Ports   : in_memdata (raw word), offset (addr[1:0]), ls (size), ls_unsigned
//           (1 = zero-extend) -> result (XLEN).
module load_extract
   import riscv_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] in_memdata,
   input  logic [1:0]      offset,
   input  logic [1:0]      ls,
   input  logic            ls_unsigned,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      half_sel = 16'h0000;
      result   = '0;

      case (offset)
         2'd0:    byte_sel = in_memdata[7:0];
         2'd1:    byte_sel = in_memdata[15:8];
         2'd2:    byte_sel = in_memdata[23:16];
         default: byte_sel = in_memdata[31:24];
      endcase

      // Halfword selection only looks at offset[1]; a misaligned offset[0] is ignored.
      half_sel = offset[1] ? in_memdata[31:16] : in_memdata[15:0];

      case (ls)
         LS_BYTE: result = {{(XLEN-8){~ls_unsigned & byte_sel[7]}}, byte_sel};
         LS_HALF: result = {{(XLEN-16){~ls_unsigned & half_sel[15]}}, half_sel};
         default: result = in_memdata;   // LS_WORD and the 2'b11 alias
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Purpose : MEM/WB pipeline register, load extraction and writeback select.
// Latency : 1 cycle from capture to wb_we/retire; loads wait up to MEM_TIMEOUT cycles.
// Backpressure: stall_req (combinational) holds IF..MEM while a load waits for mem_rvalid.
// Ports   : clk, rst (async, active-high), bus (mem_wb_stage_if.slave).
// Option  : MEM_WB_INSTRET_EN enables the 64-bit retired-instruction counter;
//           when undefined instret is tied to zero.
module mem_wb_stage
   import riscv_pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int XLEN        = 32
) (
   input logic          clk,
   input logic          rst,
   mem_wb_stage_if.slave bus
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   wb_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic            capture;
   logic            timeout_hit;
   logic            stall_raw;

   logic            wb_we_q;
   logic [4:0]      wb_addr_q;
   logic [XLEN-1:0] wb_data_q;
   logic            retire_q;
   logic            load_err_q;

   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] wb_sel;

   logic is_load;
   assign is_load = bus.in_control[CTRL_MEMREAD];

   // Branch/MemWrite and the reserved bits do not affect writeback.
   logic unused_ctrl;
   assign unused_ctrl = ^{bus.in_control[7:6],
                          bus.in_control[CTRL_BRANCH],
                          bus.in_control[CTRL_MEMWRITE]};

   load_extract #(.XLEN(XLEN)) u_load_extract (
      .in_memdata  (bus.in_memdata),
      .offset      (bus.in_regdata[1:0]),
      .ls          (bus.in_ls),
      .ls_unsigned (bus.in_ls_unsigned),
      .result      (load_data)
   );

   // Link beats MemToReg beats the ALU result.
   always_comb begin
      wb_sel = bus.in_regdata;
      if (bus.in_control[CTRL_LINK])
         wb_sel = bus.in_pc + XLEN'(4);
      else if (bus.in_control[CTRL_MEMTOREG])
         wb_sel = load_data;
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      stall_raw   = 1'b0;

      case (state)
         RUN: begin
            if (bus.in_valid) begin
               if (!is_load || bus.mem_rvalid) begin
                  capture = 1'b1;
               end else begin
                  stall_raw = 1'b1;
                  state_nxt = LOAD_WAIT;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end
         LOAD_WAIT: begin
            // Data arriving on the last allowed cycle still completes the load.
            if (bus.mem_rvalid) begin
               capture   = 1'b1;
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else if (cnt >= CNT_W'(MEM_TIMEOUT)) begin
               // Release the stall so MEM can drop the aborted load.
               timeout_hit = 1'b1;
               state_nxt   = RUN;
               cnt_nxt     = '0;
            end else begin
               stall_raw = 1'b1;
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // stall_req is combinational from the inputs, so force it low while in reset.
   assign bus.stall_req = stall_raw & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         cnt        <= '0;
         wb_we_q    <= 1'b0;
         wb_addr_q  <= 5'd0;
         wb_data_q  <= '0;
         retire_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         retire_q   <= capture;
         load_err_q <= timeout_hit;
         wb_we_q    <= capture & bus.in_control[CTRL_REGWRITE] & (|bus.in_reg_addr);
         // Address/data hold their last captured values through bubbles.
         if (capture) begin
            wb_addr_q <= bus.in_reg_addr;
            wb_data_q <= wb_sel;
         end
      end
   end

   assign bus.wb_we    = wb_we_q;
   assign bus.wb_addr  = wb_addr_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.retire   = retire_q;
   assign bus.load_err = load_err_q;

`ifdef MEM_WB_INSTRET_EN
   logic [63:0] instret_q;

   // Counts alongside capture so instret already includes the instruction
   // whose retire pulse is currently visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         instret_q <= 64'd0;
      else if (capture)
         instret_q <= instret_q + 64'd1;
   end

   assign bus.instret = instret_q;
`else
   assign bus.instret = 64'd0;
`endif

endmodule
